// File: rtl/store_buf.sv
// Store buffer: aligns and encodes M-stage stores, queues them in order and drains them to data memory.
// Optional store-to-load forwarding lookup is built when STORE_FORWARD_EN is defined.
module store_buf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  StOp,
    input  logic [31:0] Address,
    input  logic [31:0] Din,
    output logic        misalign,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic        empty,
    input  logic [31:0] fwd_addr,
    output logic        fwd_hit,
    output logic [3:0]  fwd_be,
    output logic [31:0] fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] data;
    } entry_t;

    entry_t           buf_q [DEPTH];
    entry_t           push_entry_d;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_q, misalign_d;
    logic             aligned;
    logic             req;
    logic             push;
    logic             pop;

    // Encode the incoming store into its word address, lane enables and replicated data.
    always_comb begin
        push_entry_d       = '0;
        push_entry_d.waddr = Address[31:2];
        push_entry_d.data  = Din;
        aligned            = 1'b1;
        case (StOp)
            2'b01: begin
                aligned           = (Address[1:0] == 2'b00);
                push_entry_d.be   = 4'b1111;
            end
            2'b10: begin
                aligned           = ~Address[0];
                push_entry_d.be   = Address[1] ? 4'b1100 : 4'b0011;
                push_entry_d.data = {Din[15:0], Din[15:0]};
            end
            2'b11: begin
                push_entry_d.be   = 4'b0001 << Address[1:0];
                push_entry_d.data = {4{Din[7:0]}};
            end
            default: ;
        endcase
    end

    assign st_ready = (count_q != FULL_CNT);
    assign empty    = (count_q == '0);
    assign mem_we   = ~empty;
    assign req      = st_valid && st_ready && (StOp != 2'b00);
    assign push     = req && aligned;
    assign pop      = mem_we && mem_ready;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        misalign_d = req && !aligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset; an entry is only ever observed
    // while the count marks it valid, so clearing it would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= push_entry_d;
        end
    end

    assign misalign  = misalign_q;
    assign head      = buf_q[rd_ptr_q];
    assign mem_addr  = mem_we ? {head.waddr, 2'b00} : 32'h0;
    assign mem_be    = mem_we ? head.be : 4'h0;
    assign mem_wdata = mem_we ? head.data : 32'h0;

`ifdef STORE_FORWARD_EN
    logic [PTR_W-1:0] fwd_idx;
    logic             unused_fwd_lsbs;

    assign unused_fwd_lsbs = ^fwd_addr[1:0];

    // Walk entries oldest to youngest so the youngest word match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_be   = 4'h0;
        fwd_data = 32'h0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (buf_q[fwd_idx].waddr == fwd_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_be   = buf_q[fwd_idx].be;
                fwd_data = buf_q[fwd_idx].data;
            end
        end
    end
`else
    logic unused_fwd_addr;

    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_be          = 4'h0;
    assign fwd_data        = 32'h0;
`endif

endmodule

// File: tb/tb_store_buf.sv
// Directed self-checking bench for store_buf: encoding, misalignment, full/wrap, push+pop, forwarding, reset.
module tb_store_buf;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  StOp;
    logic [31:0] Address;
    logic [31:0] Din;
    logic        misalign;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        empty;
    logic [31:0] fwd_addr;
    logic        fwd_hit;
    logic [3:0]  fwd_be;
    logic [31:0] fwd_data;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_SW   = 2'b01;
    localparam logic [1:0] OP_SH   = 2'b10;
    localparam logic [1:0] OP_SB   = 2'b11;

    store_buf #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .StOp      (StOp),
        .Address   (Address),
        .Din       (Din),
        .misalign  (misalign),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .empty     (empty),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_be    (fwd_be),
        .fwd_data  (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] din);
        st_valid = 1'b1;
        StOp     = op;
        Address  = addr;
        Din      = din;
        tick();
        st_valid = 1'b0;
        StOp     = OP_NONE;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        st_valid  = 1'b0;
        StOp      = OP_NONE;
        Address   = 32'h0;
        Din       = 32'h0;
        mem_ready = 1'b0;
        fwd_addr  = 32'h0;
        tick();
        tick();
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b expected 1", st_ready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin errors++; $display("FAIL reset_mem_bus: got %h/%b/%h expected zeros", mem_addr, mem_be, mem_wdata); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b expected 0", fwd_hit); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sb();
        push(OP_SB, 32'h13, 32'h0000d999);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sb_mem_we: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL sb_addr: got %h expected 00000010", mem_addr); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", mem_be); end
        checks++; if (mem_wdata !== 32'h99999999) begin errors++; $display("FAIL sb_wdata: got %h expected 99999999", mem_wdata); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL sb_not_empty: got %b expected 0", empty); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sb_drained: empty got %b expected 1", empty); end
    endtask

    task automatic test_nop();
        push(OP_NONE, 32'h44, 32'hdeadbeef);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL nop_empty: got %b expected 1", empty); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL nop_misalign: got %b expected 0", misalign); end
    endtask

    task automatic test_sh_misalign();
        push(OP_SH, 32'h22, 32'h1234abcd);
        checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL sh_addr: got %h expected 00000020", mem_addr); end
        checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", mem_be); end
        checks++; if (mem_wdata !== 32'habcdabcd) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", mem_wdata); end
        push(OP_SW, 32'h31, 32'h55555555);
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", misalign); end
        checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL mis_head_kept: got %h expected 00000020", mem_addr); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b expected 0", misalign); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mis_not_enqueued: empty got %b expected 1", empty); end
        push(OP_SH, 32'h27, 32'h0);
        checks++; if (misalign !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL sh_odd_misalign: misalign=%b empty=%b expected 1/1", misalign, empty); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] exp_addr [5];
        exp_addr[0] = 32'h0;
        exp_addr[1] = 32'h4;
        exp_addr[2] = 32'h8;
        exp_addr[3] = 32'hC;
        exp_addr[4] = 32'h100;
        for (int i = 0; i < 4; i++) begin
            checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b expected 1", i, st_ready); end
            push(OP_SW, exp_addr[i], 32'hA0 + 32'(i));
        end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b expected 0", st_ready); end
        st_valid = 1'b1;
        StOp     = OP_SW;
        Address  = 32'h100;
        Din      = 32'hA4;
        tick();
        checks++; if (st_ready !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'hA0) begin errors++; $display("FAIL full_stall: ready=%b addr=%h data=%h expected 0/0/a0", st_ready, mem_addr, mem_wdata); end
        mem_ready = 1'b1;
        #1;
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru: got %b expected 0", st_ready); end
        tick();
        checks++; if (st_ready !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL full_first_pop: ready=%b addr=%h expected 1/00000004", st_ready, mem_addr); end
        tick();
        st_valid = 1'b0;
        StOp     = OP_NONE;
        for (int i = 2; i < 5; i++) begin
            checks++; if (mem_addr !== exp_addr[i] || mem_wdata !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL wrap_order_%0d: got %h/%h expected %h/%h", i, mem_addr, mem_wdata, exp_addr[i], 32'hA0 + 32'(i)); end
            tick();
        end
        mem_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_drained: empty got %b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        push(OP_SB, 32'h50, 32'h00000011);
        push(OP_SH, 32'h56, 32'h00002345);
        checks++; if (mem_be !== 4'b0001 || mem_wdata !== 32'h11111111) begin errors++; $display("FAIL b2b_head: got %b/%h expected 0001/11111111", mem_be, mem_wdata); end
        mem_ready = 1'b1;
        push(OP_SW, 32'h5C, 32'hCAFEF00D);
        checks++; if (mem_addr !== 32'h54 || mem_be !== 4'b1100 || mem_wdata !== 32'h23452345) begin errors++; $display("FAIL b2b_second: got %h/%b/%h expected 00000054/1100/23452345", mem_addr, mem_be, mem_wdata); end
        tick();
        checks++; if (mem_addr !== 32'h5C || mem_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_third: got %h/%h expected 0000005c/cafef00d", mem_addr, mem_wdata); end
        tick();
        mem_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_count: empty got %b expected 1", empty); end
    endtask

    task automatic test_forward();
        logic        exp_hit;
        logic [3:0]  exp_be;
        logic [31:0] exp_data;
        push(OP_SW, 32'h40, 32'h11111111);
        fwd_addr = 32'h40;
        #1;
`ifdef STORE_FORWARD_EN
        exp_hit = 1'b1; exp_be = 4'b1111; exp_data = 32'h11111111;
`else
        exp_hit = 1'b0; exp_be = 4'b0000; exp_data = 32'h0;
`endif
        checks++; if ({fwd_hit, fwd_be, fwd_data} !== {exp_hit, exp_be, exp_data}) begin errors++; $display("FAIL fwd_first: got %b/%b/%h expected %b/%b/%h", fwd_hit, fwd_be, fwd_data, exp_hit, exp_be, exp_data); end
        push(OP_SB, 32'h41, 32'h00000022);
        fwd_addr = 32'h42;
        #1;
`ifdef STORE_FORWARD_EN
        exp_hit = 1'b1; exp_be = 4'b0010; exp_data = 32'h22222222;
`endif
        checks++; if ({fwd_hit, fwd_be, fwd_data} !== {exp_hit, exp_be, exp_data}) begin errors++; $display("FAIL fwd_youngest: got %b/%b/%h expected %b/%b/%h", fwd_hit, fwd_be, fwd_data, exp_hit, exp_be, exp_data); end
        fwd_addr = 32'h80;
        #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b expected 0", fwd_hit); end
        push(OP_SW, 32'h60, 32'h33333333);
        checks++; if (mem_addr !== 32'h40 || st_ready !== 1'b1) begin errors++; $display("FAIL fwd_three_buffered: addr=%h ready=%b expected 00000040/1", mem_addr, st_ready); end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_async: we=%b empty=%b ready=%b expected 0/1/1", mem_we, empty, st_ready); end
        checks++; if (mem_addr !== 32'h0 || fwd_hit !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: addr=%h hit=%b expected 0/0", mem_addr, fwd_hit); end
        tick();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_no_write_%0d: got %b expected 0", i, mem_we); end
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sb();
        test_nop();
        test_sh_misalign();
        test_full_wrap();
        test_back_to_back();
        test_forward();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buf.md
# store_buf

Store-side companion to the load data-extension unit. It accepts store requests from the M stage, checks alignment, and generates the word-aligned address, byte enables and lane-replicated write data. Accepted stores are held in a small in-order FIFO and drained to data memory over a valid/ready handshake. It sits between the M-stage pipeline register and the data memory write port.

## Interface
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request present
- st_ready  out  1  buffer can accept; high when entry count < DEPTH
- StOp  in  2  00 none, 01 sw, 10 sh, 11 sb
- Address  in  32  byte address of the store
- Din  in  32  register data to store (low bytes significant for sh/sb)
- misalign  out  1  one-cycle pulse: last accepted request was misaligned and was dropped
- mem_we  out  1  head entry valid (write request to memory)
- mem_ready  in  1  memory accepts the head entry this cycle
- mem_addr  out  32  {addr[31:2],2'b00} of head entry
- mem_be  out  4  byte enables of head entry
- mem_wdata  out  32  lane-replicated data of head entry
- empty  out  1  no buffered stores
- fwd_addr  in  32  load byte address for forwarding lookup
- fwd_hit  out  1  a buffered store matches fwd_addr's word
- fwd_be  out  4  byte enables of matching entry
- fwd_data  out  32  write data of matching entry

## Operation
- Accept: st_valid && st_ready && StOp!=00. StOp==00 with st_valid is consumed with no effect.
- Alignment: sw needs Address[1:0]==0; sh needs Address[0]==0; sb is always aligned. A misaligned request is consumed, not enqueued, and misalign=1 the following cycle.
- Encoding, with a = Address[1:0]:
  - sw: be=1111, data=Din.
  - sh: be = a[1] ? 1100 : 0011, data={Din[15:0],Din[15:0]}.
  - sb: be = 0001<<a, data={4{Din[7:0]}}.
- FIFO: entries hold {word address, be, data}. Circular read/write pointers and a count of width log2(DEPTH)+1; pointers wrap from DEPTH-1 to 0.
- Drain: mem_we = (count != 0). The head is popped when mem_we && mem_ready. Strict FIFO order. Outputs are driven from the head register; no combinational path from Din.
- Simultaneous push and pop: allowed when count < DEPTH; count is unchanged. When full, st_ready=0 even if a pop occurs that cycle (no pass-through).
- Forwarding: all valid entries are compared on word address. The youngest match drives fwd_be/fwd_data. There is no byte merging across entries. Lookup is combinational.

## Timing
- Reset (async assert, sync release): count=0, pointers=0, misalign=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, empty=1, st_ready=1, fwd_hit=0.
- Latency: a store accepted at edge N appears on mem_* after edge N, so it is the head in cycle N+1 when the buffer was empty.
- mem_addr/mem_be/mem_wdata are held stable while mem_we=1 and mem_ready=0.
- An entry pushed at edge N is visible to forwarding from cycle N+1.
- Reset mid-operation discards all buffered stores. No partial write is issued after rst_n falls.
- st_ready and empty are derived from registered count only.

## Configuration
- STORE_FORWARD_EN defined: forwarding compare logic is built as described.
- Not defined: fwd_hit, fwd_be and fwd_data are tied to 0 and fwd_addr is ignored. Ports remain so the instantiation is unchanged.

## Test plan
- Reset, then sb with Address=0x13, Din=0x0000d999 -> next cycle mem_we=1, mem_addr=0x10, mem_be=1000, mem_wdata=0x99999999. With mem_ready=1, empty=1 one cycle later.
- sh at 0x22 with Din=0x1234abcd -> be=1100, wdata=0xabcdabcd. Then sw at 0x31 -> misalign pulse, nothing enqueued, count unchanged.
- Hold mem_ready=0, push 4 sw (0x0,0x4,0x8,0xC) -> st_ready=0 after the 4th. A 5th request is stalled. Release mem_ready -> writes leave in order, pointers wrap, and the 5th is accepted once count<4.
- Push and pop in the same cycle at count=2 -> count stays 2 and order is preserved.
- STORE_FORWARD_EN: buffer sw 0x11111111 @0x40, then sb 0x22 @0x41, then query fwd_addr=0x42 -> fwd_hit=1, fwd_be=0010, fwd_data=0x22222222. Without the macro, fwd_hit=0.
- Drop rst_n while 3 entries are buffered -> mem_we=0 immediately, empty=1, and no writes after release.
